neuron_mac_pipe: RTL and testbench

- Parametrised, pipelined fixed-point multiply-accumulate neuron; successor to the single-lane 16-bit neuron MAC.
- Each accepted beat consumes LANES signed input/weight pairs and accumulates their products into a wide accumulator.
- On the last beat the block drains the pipeline, adds a per-neuron bias, rescales, saturates and presents one result.
- Sits between the feature/weight buffers and the activation/output buffer of the inference datapath; ready/valid on both sides.

---
 rtl/neuron_mac_pipe.sv | 239 +++++++++++++++++++++++
 tb/tb_neuron_mac_pipe.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_pipe.sv
// -----------------------------------------------------------------------------
// neuron_mac_pipe
//
// Pipelined fixed-point multiply-accumulate neuron. Each accepted beat carries
// LANES signed input/weight pairs. Their full-precision products are summed
// into a wide signed accumulator. After the last beat the block does four
// things in order: it drains the product pipeline, adds the per-neuron bias
// aligned to the product scale, rescales by FRAC_W with floor rounding, and
// saturates to DATA_W. The result is then held until downstream takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready and out_valid come straight from flops. out_data
// and out_sat stay stable while out_valid is high and out_ready is low.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   start, bias    begin a neuron (sampled in IDLE only); bias captured then
//   in_valid/in_ready/in_last, in_data, in_wt
//                  input beats; lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready, out_data, out_sat
//                  result handshake; out_sat flags a clipped result
//   busy           FSM is not IDLE
//   beat_cnt       beats accepted for the current neuron (wraps at 2^16)
//
// Build option
//   NEURON_RELU_EN  when defined, negative results (including ones clipped at
//                   the negative limit) are replaced by 0 with out_sat=0.
// -----------------------------------------------------------------------------
module neuron_mac_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*DATA_W-1:0] in_wt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_sat,
    output logic                    busy,
    output logic [15:0]             beat_cnt
);

    localparam int PROD_W = 2 * DATA_W;

    // SCALE is the registered rescale/saturate step between the bias add and
    // the result being presented. It supplies the final cycle of the
    // last-beat-to-out_valid latency.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC   = 3'd1,
        S_DRAIN = 3'd2,
        S_BIAS  = 3'd3,
        S_SCALE = 3'd4,
        S_OUT   = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic                      drain_cnt_q, drain_cnt_d;
    logic                      in_ready_q, in_ready_d;
    logic signed [PROD_W-1:0]  prod_q [LANES];
    logic signed [PROD_W-1:0]  prod_d [LANES];
    logic                      prod_vld_q, prod_vld_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [DATA_W-1:0]         bias_q, bias_d;
    logic [15:0]               beat_cnt_q, beat_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic                      beat_fire;
    logic [ACC_W-1:0]          lane_sum;
    logic [ACC_W-1:0]          bias_ext;
    logic signed [ACC_W-1:0]   acc_shr;
    logic [ACC_W-DATA_W:0]     res_hi;

    assign beat_fire = in_valid & in_ready_q & (state_q == S_ACC);

    // Bias sits at Q(FRAC_W); shifting it left by FRAC_W puts it on the
    // Q(2*FRAC_W) scale of the products.
    assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias_q[DATA_W-1]}}, bias_q, {FRAC_W{1'b0}}};

    // Rescale with an arithmetic shift, which gives floor rounding. The result
    // fits in DATA_W only if every bit from DATA_W-1 upward equals the sign.
    assign acc_shr = $signed(acc_q) >>> FRAC_W;
    assign res_hi  = acc_shr[ACC_W-1:DATA_W-1];

    // Sum of the registered lane products, each sign-extended to ACC_W.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + {{(ACC_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
        end
    end

    // Product stage: capture full-precision signed products on each accepted beat.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = prod_q[i];
            if (beat_fire) begin
                prod_d[i] = PROD_W'($signed(in_data[i*DATA_W +: DATA_W]))
                          * PROD_W'($signed(in_wt[i*DATA_W +: DATA_W]));
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        prod_vld_d  = beat_fire;
        acc_d       = acc_q;
        bias_d      = bias_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        // Products registered on the previous edge land in the accumulator now.
        if (prod_vld_q) begin
            acc_d = acc_q + lane_sum;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bias_d     = bias;
                    acc_d      = '0;
                    beat_cnt_d = '0;
                    state_d    = S_ACC;
                end
            end
            S_ACC: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (in_last) begin
                        drain_cnt_d = 1'b0;
                        state_d     = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Two cycles let the last beat's products reach the accumulator.
                if (drain_cnt_q) begin
                    state_d = S_BIAS;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            S_BIAS: begin
                // The product pipeline is empty by now, so nothing else adds this cycle.
                acc_d   = acc_q + bias_ext;
                state_d = S_SCALE;
            end
            S_SCALE: begin
                out_valid_d = 1'b1;
                out_sat_d   = 1'b0;
                out_data_d  = acc_shr[DATA_W-1:0];
`ifdef NEURON_RELU_EN
                if (acc_shr[ACC_W-1]) begin
                    out_data_d = '0;
                end else if (|res_hi) begin
                    out_data_d = {1'b0, {(DATA_W-1){1'b1}}};
                    out_sat_d  = 1'b1;
                end
`else
                if (!acc_shr[ACC_W-1] && (|res_hi)) begin
                    out_data_d = {1'b0, {(DATA_W-1){1'b1}}};
                    out_sat_d  = 1'b1;
                end else if (acc_shr[ACC_W-1] && !(&res_hi)) begin
                    out_data_d = {1'b1, {(DATA_W-1){1'b0}}};
                    out_sat_d  = 1'b1;
                end
`endif
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // in_ready is registered: it is high for exactly the cycles spent in ACC.
    assign in_ready_d = (state_d == S_ACC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 1'b0;
            in_ready_q  <= 1'b0;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            bias_q      <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            prod_vld_q  <= prod_vld_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = (state_q != S_IDLE);
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_neuron_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac_pipe
//
// Self-checking bench for neuron_mac_pipe. The driver tasks issue neurons.
// When a last beat is accepted, the expected result and its acceptance cycle
// are pushed into queues. A monitor pops the queues and compares them against
// every result handshake, the first cycle of out_valid, and output stability
// under backpressure. Expected results come from a plain-arithmetic model:
// the sum of the products plus bias*2^FRAC_W, floor-shifted, then clipped.
// -----------------------------------------------------------------------------
module tb_neuron_mac_pipe;

    localparam int DATA_W   = 16;
    localparam int FRAC_W   = 8;
    localparam int LANES    = 4;
    localparam int ACC_W    = 40;
    localparam int MAX_WAIT = 200;
    localparam int LATENCY  = 4;

    // ---------------- clock / reset / DUT ----------------
    logic                    clk       = 1'b0;
    logic                    rst       = 1'b0;
    logic                    start     = 1'b0;
    logic [DATA_W-1:0]       bias      = '0;
    logic                    in_valid  = 1'b0;
    logic                    in_last   = 1'b0;
    logic [LANES*DATA_W-1:0] in_data   = '0;
    logic [LANES*DATA_W-1:0] in_wt     = '0;
    logic                    out_ready = 1'b1;
    logic                    in_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_sat;
    logic                    busy;
    logic [15:0]             beat_cnt;

    always #5 clk = ~clk;

    neuron_mac_pipe #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W),
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .in_data  (in_data),
        .in_wt    (in_wt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    // ---------------- bookkeeping ----------------
    int                total_cnt = 0;
    int                bad_cnt   = 0;
    int                cyc       = 0;
    int                ready_mode = 0;   // 0: ready high, 1: ready low, 2: random
    longint            run_total = 0;
    int                beats     = 0;
    logic [DATA_W:0]   exp_q[$];         // {sat, data}
    int                lat_q[$];         // cycle index of the accepting edge

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint beat_sum(input logic [LANES*DATA_W-1:0] d,
                                        input logic [LANES*DATA_W-1:0] w);
        longint s = 0;
        logic [DATA_W-1:0] a, b;
        for (int i = 0; i < LANES; i++) begin
            a = d[i*DATA_W +: DATA_W];
            b = w[i*DATA_W +: DATA_W];
            s += longint'($signed(a)) * longint'($signed(b));
        end
        return s;
    endfunction

    function automatic logic [DATA_W:0] model_result(input longint acc);
        longint          r;
        longint          max_pos;
        longint          min_neg;
        logic [DATA_W:0] res;
        max_pos = (longint'(1) <<< (DATA_W - 1)) - 1;
        min_neg = -(longint'(1) <<< (DATA_W - 1));
        r = acc >>> FRAC_W;
        if (r > max_pos)      res = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        else if (r < min_neg) res = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        else                  res = {1'b0, r[DATA_W-1:0]};
`ifdef NEURON_RELU_EN
        if (r < 0) res = '0;
`endif
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] rand_op(input int mode);
        logic [DATA_W-1:0] v;
        if (mode == 0) v = DATA_W'($urandom_range(0, 4095)) - DATA_W'(2048);
        else           v = DATA_W'($urandom);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_neuron(input logic [DATA_W-1:0] b);
        int n = 0;
        while (busy !== 1'b0 && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= MAX_WAIT) chk("idle_wait", busy, 0);
        @(posedge clk);
        #1;
        start    = 1'b1;
        bias     = b;
        // A beat offered while IDLE must not be taken.
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = {$urandom, $urandom};
        in_wt    = {$urandom, $urandom};
        @(posedge clk);
        #1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        run_total = longint'($signed(b)) * (longint'(1) <<< FRAC_W);
        beats     = 0;
    endtask

    task automatic send_beat(input logic [LANES*DATA_W-1:0] d,
                             input logic [LANES*DATA_W-1:0] w,
                             input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_last  = last;
        in_data  = d;
        in_wt    = w;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= MAX_WAIT) begin
            chk("in_ready_wait", in_ready, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        beats++;
        run_total += beat_sum(d, w);
        chk("beat_cnt", beat_cnt, beats);
        if (last) begin
            exp_q.push_back(model_result(run_total));
            lat_q.push_back(cyc);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= MAX_WAIT) begin
            chk("result_wait", exp_q.size(), 0);
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    task automatic gap(input int g);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- out_ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    logic              prev_valid = 1'b0;
    logic              prev_hs    = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    logic              prev_sat   = 1'b0;
    logic [DATA_W:0]   exp_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (lat_q.size() == 0) chk("unexpected_valid", out_valid, 0);
                else                   chk("latency", cyc, lat_q.pop_front() + LATENCY);
            end
            if (out_valid && prev_valid && !prev_hs) begin
                chk("hold_data", out_data, prev_data);
                chk("hold_sat", out_sat, prev_sat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("out_data", out_data, exp_e[DATA_W-1:0]);
                    chk("out_sat", out_sat, exp_e[DATA_W]);
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            prev_data  = out_data;
            prev_sat   = out_sat;
        end
    end

    // ---------------- main sequence ----------------
    logic [LANES*DATA_W-1:0] d_v, w_v;
    logic [DATA_W-1:0]       b_v;
    int                      n_w, mode, nb;

    initial begin
        // Reset state
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // One beat: 1.0 * 0.5 on four lanes -> 2.0
        d_v = {LANES{16'h0100}};
        w_v = {LANES{16'h0080}};
        start_neuron(16'h0000);
        send_beat(d_v, w_v, 1'b1);
        wait_drain();

        // Three beats with 2-cycle gaps, bias -1.0 -> 5.0
        start_neuron(16'hFF00);
        for (int b = 0; b < 3; b++) begin
            gap(2);
            send_beat(d_v, w_v, b == 2);
        end
        wait_drain();

        // Floor rounding of a small negative product
        d_v = {16'h0000, 16'h0000, 16'h0000, 16'hFF80};
        w_v = {16'h0000, 16'h0000, 16'h0000, 16'h0001};
        start_neuron(16'h0000);
        send_beat(d_v, w_v, 1'b1);
        wait_drain();

        // Positive saturation
        d_v = {LANES{16'h7FFF}};
        w_v = {LANES{16'h7FFF}};
        start_neuron(16'h0000);
        for (int b = 0; b < 3; b++) send_beat(d_v, w_v, b == 2);
        wait_drain();

        // Negative saturation
        d_v = {LANES{16'h8000}};
        start_neuron(16'h0000);
        for (int b = 0; b < 3; b++) send_beat(d_v, w_v, b == 2);
        wait_drain();

        // Backpressure: hold the result, pulse start during OUT
        d_v = {LANES{16'h0100}};
        w_v = {LANES{16'h0080}};
        ready_mode = 1;
        start_neuron(16'h0000);
        send_beat(d_v, w_v, 1'b1);
        n_w = 0;
        while (out_valid !== 1'b1 && n_w < MAX_WAIT) begin
            @(negedge clk);
            n_w++;
        end
        if (n_w >= MAX_WAIT) chk("bp_valid_wait", out_valid, 1);
        start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_busy", busy, 1);
            chk("bp_valid", out_valid, 1);
        end
        ready_mode = 0;
        n_w = 0;
        while (!(out_valid === 1'b1 && out_ready === 1'b1) && n_w < MAX_WAIT) begin
            @(negedge clk);
            n_w++;
        end
        if (n_w >= MAX_WAIT) chk("bp_handshake_wait", out_ready, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("bp_busy_after", busy, 0);
        chk("bp_valid_after", out_valid, 0);
        @(negedge clk);
        chk("bp_start_ignored", busy, 0);
        wait_drain();

        // Reset mid-ACC after two beats aborts the neuron
        start_neuron(16'h1234);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < LANES; i++) begin
                d_v[i*DATA_W +: DATA_W] = rand_op(0);
                w_v[i*DATA_W +: DATA_W] = rand_op(0);
            end
            send_beat(d_v, w_v, 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_beat_cnt", beat_cnt, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_sat", out_sat, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fresh neuron after the abort: 1.0 * 1.0 on four lanes -> 4.0
        d_v = {LANES{16'h0100}};
        w_v = {LANES{16'h0100}};
        start_neuron(16'h0000);
        send_beat(d_v, w_v, 1'b1);
        wait_drain();

        // Randomised neurons with random gaps and random out_ready
        ready_mode = 2;
        for (int k = 0; k < 30; k++) begin
            mode = $urandom_range(0, 1);
            b_v  = rand_op(mode);
            nb   = $urandom_range(1, 6);
            start_neuron(b_v);
            for (int b = 0; b < nb; b++) begin
                gap($urandom_range(0, 2));
                for (int i = 0; i < LANES; i++) begin
                    d_v[i*DATA_W +: DATA_W] = rand_op(mode);
                    w_v[i*DATA_W +: DATA_W] = rand_op(mode);
                end
                send_beat(d_v, w_v, b == nb - 1);
            end
            wait_drain();
        end
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("leftover_results", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
